bcd_stopwatch_ctrl: RTL and testbench

Run-control block for the 4-digit BCD time counter on the display board. It decodes single-cycle start/stop, lap and clear commands, divides the system clock into count ticks, and cascades four BCD digit counters. Each digit counts 0–9 with carry ripple into the next digit. The registered digit bus feeds the 7-segment scan driver directly.

---
 rtl/bcd_stopwatch_ctrl.sv | 133 +++++++++++++
 tb/tb_bcd_stopwatch_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: stopwatch run control, count-tick prescaler and 4-digit BCD counter; LAP freeze built in with BCD_STOPWATCH_LAP_EN.
// Latency: commands and ticks land on the next clk edge; all outputs are registered.
// Backpressure: none; single-cycle commands are always accepted, priority clear > start_stop > lap.
module bcd_stopwatch_ctrl #(
    parameter int TICK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [15:0] digits,
    output logic        running,
    output logic        tick,
    output logic        overflow
);
    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

`ifdef BCD_STOPWATCH_LAP_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;
`endif

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [15:0]   count, count_n, count_inc, digits_n;
    logic          carry_out, tick_n, ovf_n, counting, running_n;

    // Ripple increment; any digit >= 9 (including stray A-F) rolls to 0 and carries.
    always_comb begin
        count_inc = count;
        carry_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry_out) begin
                if (count[4*i +: 4] >= 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry_out = 1'b0;
                end
            end
        end
    end

`ifdef BCD_STOPWATCH_LAP_EN
    logic [15:0] lap_q, lap_n;
    assign counting  = (state == S_RUN) || (state == S_LAP);
    assign running_n = (state_n == S_RUN) || (state_n == S_LAP);
    assign digits_n  = (state_n == S_LAP) ? lap_n : count_n;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign counting   = (state == S_RUN);
    assign running_n  = (state_n == S_RUN);
    assign digits_n   = count_n;
`endif

    always_comb begin
        state_n = state;
        presc_n = presc;
        count_n = count;
        tick_n  = 1'b0;
        ovf_n   = overflow;
`ifdef BCD_STOPWATCH_LAP_EN
        lap_n   = lap_q;
`endif
        if (counting) begin
            if (presc == PRESC_LAST) begin
                presc_n = '0;
                tick_n  = 1'b1;
                count_n = count_inc;
                if (carry_out) ovf_n = 1'b1;
            end else begin
                presc_n = presc + 1'b1;
            end
        end

        if (clear) begin
            state_n = S_IDLE;
            presc_n = '0;
            count_n = '0;
            tick_n  = 1'b0;
            ovf_n   = 1'b0;
`ifdef BCD_STOPWATCH_LAP_EN
            lap_n   = '0;
`endif
        end else if (start_stop) begin
            case (state)
                S_IDLE, S_PAUSE: state_n = S_RUN;
                default:         state_n = S_PAUSE;
            endcase
        end
`ifdef BCD_STOPWATCH_LAP_EN
        else if (lap) begin
            // Capture uses count_n so a tick on the same edge is included.
            if (state == S_RUN) begin
                state_n = S_LAP;
                lap_n   = count_n;
            end else if (state == S_LAP) begin
                state_n = S_RUN;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            presc    <= '0;
            count    <= '0;
            digits   <= '0;
            running  <= 1'b0;
            tick     <= 1'b0;
            overflow <= 1'b0;
`ifdef BCD_STOPWATCH_LAP_EN
            lap_q    <= '0;
`endif
        end else begin
            state    <= state_n;
            presc    <= presc_n;
            count    <= count_n;
            digits   <= digits_n;
            running  <= running_n;
            tick     <= tick_n;
            overflow <= ovf_n;
`ifdef BCD_STOPWATCH_LAP_EN
            lap_q    <= lap_n;
`endif
        end
    end
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Testbench for bcd_stopwatch_ctrl with TICK_DIV=4: directed scenarios plus random commands
// against an integer-count reference model.
module tb_bcd_stopwatch_ctrl;
    localparam int DIV = 4;
`ifdef BCD_STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] digits;
    logic        running, tick, overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integer count, phase within the tick period, run/frozen flags.
    int m_count, m_phase, m_lap;
    bit m_run, m_frozen, m_ovf, m_tick;

    always #5 clk = ~clk;

    bcd_stopwatch_ctrl #(.TICK_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .digits     (digits),
        .running    (running),
        .tick       (tick),
        .overflow   (overflow)
    );

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_phase = 0; m_lap = 0;
        m_run = 0; m_frozen = 0; m_ovf = 0; m_tick = 0;
    endtask

    task automatic model_step(input bit c, input bit s, input bit l);
        m_tick = 0;
        if (m_run) begin
            if (m_phase == DIV - 1) begin
                m_phase = 0;
                m_tick  = 1;
                if (m_count == 9999) m_ovf = 1;
                m_count = (m_count + 1) % 10000;
            end else begin
                m_phase++;
            end
        end
        if (c) begin
            model_reset();
        end else if (s) begin
            if (m_frozen) begin
                m_frozen = 0;
                m_run    = 0;
            end else begin
                m_run = !m_run;
            end
        end else if (l && LAP_EN && m_run) begin
            if (m_frozen) begin
                m_frozen = 0;
            end else begin
                m_frozen = 1;
                m_lap    = m_count;
            end
        end
    endtask

    task automatic compare_all();
        check("digits", 32'(digits), 32'(m_frozen ? to_bcd(m_lap) : to_bcd(m_count)));
        check("running", 32'(running), 32'(m_run));
        check("tick", 32'(tick), 32'(m_tick));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step(input bit c, input bit s, input bit l);
        clear = c; start_stop = s; lap = l;
        @(posedge clk);
        model_step(c, s, l);
        #1;
        clear = 1'b0; start_stop = 1'b0; lap = 1'b0;
        compare_all();
    endtask

    task automatic run_to(input int target, input int limit);
        int n = 0;
        while (!(m_run && m_count == target && m_phase == 0) && n < limit) begin
            step(0, 0, 0);
            n++;
        end
        check("run_to", 32'(digits), 32'(to_bcd(target)));
    endtask

    initial begin
        model_reset();
        #2;
        check("rst_digits", 32'(digits), 0);
        check("rst_running", 32'(running), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_overflow", 32'(overflow), 0);
        @(negedge clk);
        rst = 1'b0;

        // Start: first tick exactly DIV cycles after running rises.
        step(0, 1, 0);
        check("start_running", 32'(running), 1);
        repeat (DIV - 1) step(0, 0, 0);
        check("pre_tick", 32'(tick), 0);
        step(0, 0, 0);
        check("tick1", 32'(tick), 1);
        check("digits_1", 32'(digits), 32'h0001);
        repeat (DIV) step(0, 0, 0);
        check("digits_2", 32'(digits), 32'h0002);

        // Pause keeps the partial prescaler period.
        run_to(5, 100);
        step(0, 0, 0);
        step(0, 1, 0);
        repeat (20) step(0, 0, 0);
        check("pause_hold", 32'(digits), 32'h0005);
        check("pause_running", 32'(running), 0);
        step(0, 1, 0);
        step(0, 0, 0);
        check("resume_1", 32'(digits), 32'h0005);
        step(0, 0, 0);
        check("resume_2", 32'(digits), 32'h0006);

        run_to(9, 100);
        repeat (DIV) step(0, 0, 0);
        check("carry_0010", 32'(digits), 32'h0010);

        run_to(9999, 45000);
        repeat (DIV) step(0, 0, 0);
        check("wrap_digits", 32'(digits), 0);
        check("wrap_overflow", 32'(overflow), 1);

        run_to(42, 400);
        check("ovf_sticky", 32'(overflow), 1);
        step(1, 1, 1);
        check("combo_digits", 32'(digits), 0);
        check("combo_running", 32'(running), 0);
        check("combo_overflow", 32'(overflow), 0);
        repeat (2 * DIV) step(0, 0, 0);
        check("combo_idle", 32'(digits), 0);

        // Lap freeze and release.
        step(0, 1, 0);
        run_to(3, 100);
        step(0, 0, 1);
        repeat (8) step(0, 0, 0);
`ifdef BCD_STOPWATCH_LAP_EN
        check("lap_frozen", 32'(digits), 32'h0003);
`endif
        step(0, 0, 1);
`ifdef BCD_STOPWATCH_LAP_EN
        check("lap_release", 32'(digits), 32'h0005);
`endif

        // Asynchronous reset mid-period.
        step(1, 0, 0);
        step(0, 1, 0);
        run_to(17, 200);
        step(0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_digits", 32'(digits), 0);
        check("arst_running", 32'(running), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        compare_all();

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
